// File: rtl/fp_regfile.sv
// Floating-point register file with write-through bypass, sticky FCSR exception
// flags and a free-running committed-write counter.
module fp_regfile #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 64,
    parameter int NFLAGS = 5,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     read_reg1,
    input  logic [AW-1:0]     read_reg2,
    output logic [DATA_W-1:0] read_f_data1,
    output logic [DATA_W-1:0] read_f_data2,
    input  logic              write_en,
    input  logic [AW-1:0]     write_reg,
    input  logic              write_fmt,
    input  logic [DATA_W-1:0] write_f_data,
    input  logic              flag_valid,
    input  logic [NFLAGS-1:0] flag_in,
    input  logic              flag_clr,
    output logic [NFLAGS-1:0] fcsr_flags,
    output logic [15:0]       write_count
);

    localparam int HALF_W = DATA_W / 2;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] wdata;
    logic [NFLAGS-1:0] flags_q, flags_d;
    logic [15:0]       count_q, count_d;

    // Single-precision writes keep the upper half and zero the lower half.
    always_comb begin
        wdata = write_f_data;
        if (!write_fmt) begin
            wdata[HALF_W-1:0] = '0;
        end
    end

    // Bypass is suppressed during reset so both ports read zero.
    always_comb begin
        read_f_data1 = regs_q[read_reg1];
        read_f_data2 = regs_q[read_reg2];
        if (rst_n && write_en && (read_reg1 == write_reg)) begin
            read_f_data1 = wdata;
        end
        if (rst_n && write_en && (read_reg2 == write_reg)) begin
            read_f_data2 = wdata;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (flag_clr) begin
            flags_d = flag_valid ? flag_in : '0;
        end else if (flag_valid) begin
            flags_d = flags_q | flag_in;
        end
    end

    always_comb begin
        count_d = count_q;
        if (write_en) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_en) begin
            regs_q[write_reg] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            count_q <= '0;
        end else begin
            flags_q <= flags_d;
            count_q <= count_d;
        end
    end

    assign fcsr_flags  = flags_q;
    assign write_count = count_q;

endmodule

// File: tb/tb_fp_regfile.sv
// Directed bench for fp_regfile: reset, fmt masking, bypass, sticky flags, counter wrap.
module tb_fp_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  read_reg1, read_reg2, write_reg;
    logic [63:0] read_f_data1, read_f_data2, write_f_data;
    logic        write_en, write_fmt, flag_valid, flag_clr;
    logic [4:0]  flag_in, fcsr_flags;
    logic [15:0] write_count;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    fp_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_f_data1(read_f_data1), .read_f_data2(read_f_data2),
        .write_en(write_en), .write_reg(write_reg), .write_fmt(write_fmt),
        .write_f_data(write_f_data),
        .flag_valid(flag_valid), .flag_in(flag_in), .flag_clr(flag_clr),
        .fcsr_flags(fcsr_flags), .write_count(write_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; the expected counter follows committed writes.
    task automatic tick();
        if (write_en && rst_n) exp_cnt = (exp_cnt + 1) % 65536;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; write_en = 0; write_fmt = 0; write_reg = 0; write_f_data = '0;
        read_reg1 = 0; read_reg2 = 0; flag_valid = 0; flag_in = 0; flag_clr = 0;
        @(posedge clk); #1;
        chk("reset_count", 64'(write_count), 64'd0);
        chk("reset_flags", 64'(fcsr_flags), 64'd0);
        rst_n = 1'b1;

        // Preload f3 and some flags, then pulse reset mid-cycle with a write pending.
        write_en = 1; write_fmt = 1; write_reg = 3; write_f_data = 64'h4049_0FDB_0000_0000;
        flag_valid = 1; flag_in = 5'b00011;
        tick();
        flag_valid = 0; write_en = 0; read_reg1 = 3; read_reg2 = 3;
        #1;
        chk("preload_f3", read_f_data1, 64'h4049_0FDB_0000_0000);
        chk("preload_count", 64'(write_count), 64'(exp_cnt));
        chk("preload_flags", 64'(fcsr_flags), 64'h03);
        write_en = 1; write_f_data = 64'h1111_2222_3333_4444;
        #2;
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        chk("async_rd1", read_f_data1, 64'd0);
        chk("async_rd2", read_f_data2, 64'd0);
        chk("async_flags", 64'(fcsr_flags), 64'd0);
        chk("async_count", 64'(write_count), 64'd0);
        tick();
        write_en = 0;
        rst_n = 1'b1;
        #1;
        chk("discard_f3", read_f_data1, 64'd0);
        chk("discard_count", 64'(write_count), 64'd0);

        // Double write, read next cycle.
        write_en = 1; write_fmt = 1; write_reg = 7; write_f_data = 64'h4009_21FB_5444_2D18;
        tick();
        write_en = 0; read_reg1 = 7; read_reg2 = 8;
        #1;
        chk("dbl_f7", read_f_data1, 64'h4009_21FB_5444_2D18);
        chk("dbl_f8", read_f_data2, 64'd0);

        // Single write masks the low half.
        write_en = 1; write_fmt = 1; write_reg = 5; write_f_data = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        write_fmt = 0; write_f_data = 64'h3F80_0000_1234_5678;
        tick();
        write_en = 0; read_reg1 = 5;
        #1;
        chk("sgl_f5", read_f_data1, 64'h3F80_0000_0000_0000);

        // Dual-port bypass, then the committed value.
        write_en = 1; write_fmt = 1; write_reg = 9; write_f_data = 64'hC000_0000_0000_0000;
        read_reg1 = 9; read_reg2 = 9;
        #1;
        chk("byp_rd1", read_f_data1, 64'hC000_0000_0000_0000);
        chk("byp_rd2", read_f_data2, 64'hC000_0000_0000_0000);
        write_fmt = 0; write_f_data = 64'h4000_0000_DEAD_BEEF; write_reg = 9;
        #1;
        chk("byp_sgl_mask", read_f_data2, 64'h4000_0000_0000_0000);
        write_fmt = 1; write_f_data = 64'hC000_0000_0000_0000;
        tick();
        write_en = 0;
        #1;
        chk("byp_f9_after", read_f_data1, 64'hC000_0000_0000_0000);
        chk("count_after_writes", 64'(write_count), 64'(exp_cnt));

        // Sticky flags.
        flag_valid = 1; flag_in = 5'b00001;
        tick();
        flag_in = 5'b10000;
        tick();
        flag_valid = 0;
        #1;
        chk("flags_or", 64'(fcsr_flags), 64'b10001);
        tick();
        chk("flags_hold", 64'(fcsr_flags), 64'b10001);
        flag_clr = 1; flag_valid = 1; flag_in = 5'b00100;
        tick();
        chk("flags_clr_set", 64'(fcsr_flags), 64'b00100);
        flag_valid = 0;
        tick();
        flag_clr = 0;
        chk("flags_clr", 64'(fcsr_flags), 64'd0);

        // write_en low changes nothing.
        write_en = 0; write_fmt = 1; write_reg = 7; write_f_data = 64'h0123_4567_89AB_CDEF;
        read_reg1 = 7; read_reg2 = 9;
        tick();
        chk("noen_f7", read_f_data1, 64'h4009_21FB_5444_2D18);
        chk("noen_f9", read_f_data2, 64'hC000_0000_0000_0000);
        chk("noen_count", 64'(write_count), 64'(exp_cnt));

        // Counter wrap after 65536 writes from reset.
        rst_n = 1'b0;
        exp_cnt = 0;
        #1;
        rst_n = 1'b1;
        write_en = 1;
        for (int i = 0; i < 65535; i++) begin
            write_reg = 5'($urandom_range(31));
            write_f_data = {$urandom, $urandom};
            write_fmt = 1'($urandom_range(1));
            tick();
        end
        chk("count_ffff", 64'(write_count), 64'hFFFF);
        tick();
        write_en = 0;
        chk("count_wrap", 64'(write_count), 64'd0);
        chk("count_model", 64'(write_count), 64'(exp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
